// File: rtl/imem_loader_pkg.sv
// Shared constants for the writable instruction memory: instruction field
// widths, the NOP word served for unloaded addresses, and the loader states.
package imem_loader_pkg;

  localparam int W_INSTYPE = 2;
  localparam int W_IR      = 1;
  localparam int W_OPCODE  = 4;
  localparam int W_TGT     = 3;
  localparam int W_AMUX    = 3;
  localparam int W_BMUX    = 8;

  localparam int INS_W =
    W_INSTYPE + W_IR + W_OPCODE + W_TGT + W_AMUX + W_BMUX;

  localparam int CHUNK_W = 7;

  localparam logic [INS_W-1:0] NOP_WORD =
    {2'b01, 1'b0, 4'b0111, 3'b000, 3'b000, 8'h00};

  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_EXEC = 2'd2;

  localparam logic [1:0] PH_HI  = 2'd0;
  localparam logic [1:0] PH_MID = 2'd1;
  localparam logic [1:0] PH_LO  = 2'd2;

endpackage

// File: rtl/imem_loader_strobe.sv
// Strobe conditioning: 2-flop synchronizer plus rising-edge detector.
// Ports: clk, rst_n (async low), stb (raw key), pulse (one-cycle pulse).
module strobe_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic stb,
  output logic pulse
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= stb;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // s3 is the previous synchronized level; a held key pulses once.
  assign pulse = s2 & ~s3;

endmodule

// File: rtl/imem_loader.sv
// Writable instruction memory loaded in 7-bit chunks from switches.
// Ports: CLK, RESET_N, ADDR, DIN, STB, RUN in; INS, MANUAL_LOAD,
// LOAD_ADDR, WCOUNT, PHASE out.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter logic [20:0] NOP = NOP_WORD
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [7:0]  ADDR,
  input  logic [6:0]  DIN,
  input  logic        STB,
  input  logic        RUN,
  output logic [20:0] INS,
  output logic        MANUAL_LOAD,
  output logic [7:0]  LOAD_ADDR,
  output logic [8:0]  WCOUNT,
  output logic [1:0]  PHASE
);

  localparam logic [8:0] FULL = 9'(DEPTH);

  logic [1:0]  state;
  logic [6:0]  hi;
  logic [6:0]  mid;
  logic        stb_pulse;
  logic        cap;
  logic        we;
  logic [20:0] mem [DEPTH];

  strobe_sync u_sync (
    .clk   (CLK),
    .rst_n (RESET_N),
    .stb   (STB),
    .pulse (stb_pulse)
  );

  assign cap = (state == ST_LOAD) && stb_pulse;
  assign we  = cap && (PHASE == PH_LO);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= ST_LOAD;
      hi        <= '0;
      mid       <= '0;
      PHASE     <= PH_HI;
      LOAD_ADDR <= '0;
      WCOUNT    <= '0;
    end else begin
      unique case (1'b1)
        (state == ST_LOAD): begin
          // A capture takes priority; RUN is rechecked next cycle.
          if (cap) begin
            unique case (1'b1)
              (PHASE == PH_HI): begin
                hi    <= DIN;
                PHASE <= PH_MID;
              end
              (PHASE == PH_MID): begin
                mid   <= DIN;
                PHASE <= PH_LO;
              end
              default: begin
                PHASE     <= PH_HI;
                LOAD_ADDR <= LOAD_ADDR + 8'd1;
                if (WCOUNT != FULL)
                  WCOUNT <= WCOUNT + 9'd1;
              end
            endcase
          end else if (RUN && PHASE == PH_HI) begin
            state <= ST_ARM;
          end
        end
        (state == ST_ARM): begin
          state <= ST_EXEC;
        end
        default: begin
          if (!RUN) begin
            state     <= ST_LOAD;
            PHASE     <= PH_HI;
            LOAD_ADDR <= '0;
            WCOUNT    <= '0;
          end
        end
      endcase
    end
  end

  // Contents are never reset; WCOUNT alone marks them valid.
  always_ff @(posedge CLK) begin
    if (we)
      mem[LOAD_ADDR] <= {hi, mid, DIN};
  end

  assign INS = ({1'b0, ADDR} < WCOUNT) ? mem[ADDR] : NOP;

  assign MANUAL_LOAD = (state != ST_EXEC);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: reset, chunk loading, strobe
// conditioning, run handoff, re-entry, mid-load reset and wrap.
module tb_imem_loader;

  logic        clk;
  logic        rst_n;
  logic [7:0]  addr;
  logic [6:0]  din;
  logic        stb;
  logic        run;
  logic [20:0] ins;
  logic        ml;
  logic [7:0]  la;
  logic [8:0]  wc;
  logic [1:0]  ph;

  int checks;
  int failures;

  localparam logic [20:0] NOPW = 21'h09C000;

  imem_loader dut (
    .CLK         (clk),
    .RESET_N     (rst_n),
    .ADDR        (addr),
    .DIN         (din),
    .STB         (stb),
    .RUN         (run),
    .INS         (ins),
    .MANUAL_LOAD (ml),
    .LOAD_ADDR   (la),
    .WCOUNT      (wc),
    .PHASE       (ph)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [6:0] v, input int hold);
    din = v;
    stb = 1'b1;
    step(hold);
    stb = 1'b0;
    step(3);
  endtask

  task automatic load_word(input logic [20:0] w);
    strobe(w[20:14], 3);
    strobe(w[13:7], 3);
    strobe(w[6:0], 3);
  endtask

  task automatic ins_at(input logic [7:0] a, output logic [20:0] v);
    addr = a;
    #1;
    v = ins;
  endtask

  logic [20:0] v;
  int cyc;

  initial begin
    checks   = 0;
    failures = 0;
    rst_n = 1'b0;
    addr  = '0;
    din   = '0;
    stb   = 1'b0;
    run   = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);

    chk("rst_ml", 32'(ml), 32'd1);
    chk("rst_wc", 32'(wc), 32'd0);
    chk("rst_ph", 32'(ph), 32'd0);
    chk("rst_la", 32'(la), 32'd0);
    ins_at(8'd0, v);
    chk("rst_ins", 32'(v), 32'(NOPW));

    // First chunk capture lands on the third edge after STB rises.
    din = 7'h17;
    stb = 1'b1;
    step(2);
    chk("lat_e2", 32'(ph), 32'd0);
    step(1);
    chk("lat_e3", 32'(ph), 32'd1);
    stb = 1'b0;
    step(3);
    strobe(7'h00, 3);
    strobe(7'h00, 3);
    chk("w0_wc", 32'(wc), 32'd1);
    chk("w0_la", 32'(la), 32'd1);
    ins_at(8'd0, v);
    chk("w0_ins0", 32'(v), 32'h05C000);
    ins_at(8'd1, v);
    chk("w0_ins1", 32'(v), 32'(NOPW));

    strobe(7'h01, 10);
    chk("hold_ph", 32'(ph), 32'd1);
    din = 7'h02;
    @(posedge clk);
    #8 stb = 1'b1;
    #4 stb = 1'b0;
    step(4);
    chk("glitch_ph", 32'(ph), 32'd2);
    strobe(7'h03, 3);
    chk("w1_wc", 32'(wc), 32'd2);
    ins_at(8'd1, v);
    chk("w1_ins", 32'(v), 32'h004103);

    run = 1'b1;
    step(1);
    chk("arm_ml", 32'(ml), 32'd1);
    step(1);
    chk("exec_ml", 32'(ml), 32'd0);
    ins_at(8'd1, v);
    chk("exec_ins1", 32'(v), 32'h004103);
    ins_at(8'd2, v);
    chk("exec_ins2", 32'(v), 32'(NOPW));

    strobe(7'h7F, 3);
    chk("exec_ign_ph", 32'(ph), 32'd0);
    chk("exec_ign_wc", 32'(wc), 32'd2);
    run = 1'b0;
    step(1);
    chk("reent_ml", 32'(ml), 32'd1);
    chk("reent_wc", 32'(wc), 32'd0);
    chk("reent_la", 32'(la), 32'd0);
    ins_at(8'd0, v);
    chk("reent_ins", 32'(v), 32'(NOPW));

    strobe(7'h11, 3);
    run = 1'b1;
    step(4);
    chk("part_ml", 32'(ml), 32'd1);
    chk("part_ph", 32'(ph), 32'd1);
    strobe(7'h22, 3);
    chk("part_ml2", 32'(ml), 32'd1);
    strobe(7'h33, 3);
    cyc = 0;
    while (ml !== 1'b0 && cyc < 10) begin
      step(1);
      cyc++;
    end
    chk("part_exec", 32'(ml), 32'd0);
    chk("part_wc", 32'(wc), 32'd1);
    ins_at(8'd0, v);
    chk("part_ins", 32'(v), 32'h045133);
    run = 1'b0;
    step(1);

    strobe(7'h05, 3);
    strobe(7'h06, 3);
    chk("mid_ph2", 32'(ph), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("mid_ph", 32'(ph), 32'd0);
    chk("mid_wc", 32'(wc), 32'd0);
    chk("mid_ml", 32'(ml), 32'd1);
    chk("mid_la", 32'(la), 32'd0);
    step(1);
    rst_n = 1'b1;
    step(1);

    for (int i = 0; i < 257; i++) begin
      load_word(21'(i));
    end
    chk("wrap_wc", 32'(wc), 32'd256);
    chk("wrap_la", 32'(la), 32'd1);
    chk("wrap_ph", 32'(ph), 32'd0);
    ins_at(8'd0, v);
    chk("wrap_ins0", 32'(v), 32'd256);
    ins_at(8'd128, v);
    chk("wrap_ins128", 32'(v), 32'd128);
    ins_at(8'd255, v);
    chk("wrap_ins255", 32'(v), 32'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
